// File: rtl/uart_pkg.sv
// UART shared definitions: frame FSM states and default framing.
// Used by the tx arbiter and the receiver.
package uart_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  function automatic int frame_len(
    input int data_w,
    input int stop_bits
  );
    return 1 + data_w + stop_bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping modulo N, wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int             w_sum;
  logic [IW-1:0]  w_pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_sum   = 0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_pos = IW'(w_sum);
      if (enable && !any && req[w_pos]) begin
        any        = 1'b1;
        gnt[w_pos] = 1'b1;
        gnt_idx    = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter: grants one producer per frame,
// then serialises start, LSB-first data and stop bits on baud ticks.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = UART_DATA_W,
  parameter int STOP_BITS = UART_STOP_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        baud_tick,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        tx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e         r_state;
  logic [NUM_REQ-1:0]  r_ready;
  logic [IW-1:0]       r_grant;
  logic [IW-1:0]       r_ptr;
  logic [DATA_W-1:0]   r_shift;
  logic [BW-1:0]       r_bit;
  logic                r_stop;
  logic                r_busy;
  logic                r_done;
  logic                r_tx;

  logic                w_idle;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_data;
  logic [IW-1:0]       w_ptr_nxt;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_data    = req_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_ptr_nxt = (w_idx == IW'(NUM_REQ - 1)) ? '0
                                                 : w_idx + 1'b1;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .enable  (w_idle),
    .gnt     (w_gnt),
    .gnt_idx (w_idx),
    .any     (w_any)
  );

  // A tick landing while req_ready is still up belongs to the grant
  // cycle and must not start the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ready <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_ready <= '0;
      r_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_any) begin
            r_ready <= w_gnt;
            r_grant <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_shift <= w_data;
            r_busy  <= 1'b1;
            r_state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (baud_tick && (r_ready == '0)) begin
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (r_bit == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_stop  <= 1'b0;
              r_state <= ST_STOP;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (r_stop == LAST_STOP) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_stop  <= r_stop + 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign grant_id   = r_grant;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign tx         = r_tx;

endmodule
